// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front end for the 4-bit ALU datapath.
// Drives registered A/B/SEL operands, captures the ALU result into an
// accumulator and returns each result over a valid/ready response channel.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN (registered result-is-zero flag).
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SEL_W = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [SEL_W-1:0] cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

    // Sequencer FSM; cmd_ready is a flop that tracks (state == IDLE) exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            acc       <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            op_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (cmd_load) begin
                            acc       <= cmd_data;
                            res_data  <= cmd_data;
                            res_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_a   <= acc;
                            alu_b   <= cmd_data;
                            alu_sel <= cmd_op;
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    acc       <= alu_out;
                    res_data  <= alu_out;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_cnt    <= op_cnt + CNT_W'(1);
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    // Zero flag loaded with the same value that lands in res_data, cleared on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_zero <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (cmd_valid && cmd_load) res_zero <= (cmd_data == '0);
                EXEC:    res_zero <= (alu_out == '0);
                RESP:    if (res_ready) res_zero <= 1'b0;
                default: res_zero <= 1'b0;
            endcase
        end
    end
`else
    // Flag feature disabled: port kept, tied low
    assign res_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with an adder ALU stub.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_out;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_zero;
    logic [3:0] acc;
    logic [7:0] op_cnt;

    int checks;
    int errors;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    localparam logic ZF = 1'b1;
`else
    localparam logic ZF = 1'b0;
`endif

    alu_cmd_sequencer #(.WIDTH(4), .SEL_W(3), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .acc       (acc),
        .op_cnt    (op_cnt)
    );

    // ALU stub: (A + B) mod 16
    assign alu_out = alu_a + alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 4'd0;
        res_ready = 1'b0;

        // Asynchronous reset asserted mid-cycle, before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_acc",       32'(acc),       32'h0);
        chk("rst_alu_a",     32'(alu_a),     32'h0);
        chk("rst_alu_b",     32'(alu_b),     32'h0);
        chk("rst_alu_sel",   32'(alu_sel),   32'h0);
        chk("rst_res_data",  32'(res_data),  32'h0);
        chk("rst_op_cnt",    32'(op_cnt),    32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_zero",  32'(res_zero),  32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

        // LOAD 0x5
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 4'h5;
        tick();
        cmd_valid = 1'b0;
        chk("load5_res_valid", 32'(res_valid), 32'h1);
        chk("load5_res_data",  32'(res_data),  32'h5);
        chk("load5_acc",       32'(acc),       32'h5);
        chk("load5_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("load5_alu_a",     32'(alu_a),     32'h0);
        res_ready = 1'b1;
        tick();
        chk("load5_hs_valid", 32'(res_valid), 32'h0);
        chk("load5_hs_cnt",   32'(op_cnt),    32'h1);
        chk("load5_hs_ready", 32'(cmd_ready), 32'h1);

        // Execute add 0x3 with res_ready already high (ignored until RESP)
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'b000; cmd_data = 4'h3;
        tick();
        cmd_valid = 1'b0;
        chk("add_alu_a",     32'(alu_a),     32'h5);
        chk("add_alu_b",     32'(alu_b),     32'h3);
        chk("add_alu_sel",   32'(alu_sel),   32'h0);
        chk("add_exec_vld",  32'(res_valid), 32'h0);
        chk("add_exec_rdy",  32'(cmd_ready), 32'h0);
        chk("add_exec_cnt",  32'(op_cnt),    32'h1);
        tick();
        chk("add_res_valid", 32'(res_valid), 32'h1);
        chk("add_res_data",  32'(res_data),  32'h8);
        chk("add_acc",       32'(acc),       32'h8);
        tick();
        chk("add_hs_cnt",    32'(op_cnt),    32'h2);
        chk("add_hs_valid",  32'(res_valid), 32'h0);
        chk("add_hs_ready",  32'(cmd_ready), 32'h1);

        // Back-pressure: result 8+2 = 0xA held while a new load waits on cmd_valid
        res_ready = 1'b0;
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd5; cmd_data = 4'h2;
        tick();
        cmd_load = 1'b1; cmd_op = 3'd0; cmd_data = 4'h7;
        chk("bp_alu_sel", 32'(alu_sel), 32'h5);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_res_valid", 32'(res_valid), 32'h1);
            chk("bp_res_data",  32'(res_data),  32'hA);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'h0);
            chk("bp_acc",       32'(acc),       32'hA);
            chk("bp_res_zero",  32'(res_zero),  32'h0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_hs_valid", 32'(res_valid), 32'h0);
        chk("bp_hs_cnt",   32'(op_cnt),    32'h3);
        chk("bp_hs_ready", 32'(cmd_ready), 32'h1);
        chk("bp_hs_acc",   32'(acc),       32'hA);
        tick();
        cmd_valid = 1'b0;
        chk("bp_load7_valid", 32'(res_valid), 32'h1);
        chk("bp_load7_data",  32'(res_data),  32'h7);
        chk("bp_load7_acc",   32'(acc),       32'h7);
        res_ready = 1'b1;
        tick();
        chk("bp_load7_cnt", 32'(op_cnt), 32'h4);

        // Wrap to zero: LOAD 0xF then add 0x1
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 4'hF;
        tick();
        cmd_valid = 1'b0;
        chk("wrapF_res_data", 32'(res_data), 32'hF);
        chk("wrapF_res_zero", 32'(res_zero), 32'h0);
        tick();
        chk("wrapF_cnt", 32'(op_cnt), 32'h5);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'b000; cmd_data = 4'h1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("wrap0_res_valid", 32'(res_valid), 32'h1);
        chk("wrap0_res_data",  32'(res_data),  32'h0);
        chk("wrap0_acc",       32'(acc),       32'h0);
        chk("wrap0_res_zero",  32'(res_zero),  32'(ZF));
        tick();
        chk("wrap0_hs_cnt",  32'(op_cnt),   32'h6);
        chk("wrap0_hs_zero", 32'(res_zero), 32'h0);

        // Reset while in EXEC: result dropped, everything back to reset values
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 4'h3;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_pre_acc", 32'(acc), 32'h3);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_data = 4'h4;
        tick();
        cmd_valid = 1'b0;
        chk("mid_exec_alu_b", 32'(alu_b), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_acc",       32'(acc),       32'h0);
        chk("mid_rst_cnt",       32'(op_cnt),    32'h0);
        chk("mid_rst_valid",     32'(res_valid), 32'h0);
        chk("mid_rst_alu_a",     32'(alu_a),     32'h0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'h1);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("mid_after_valid", 32'(res_valid), 32'h0);
        chk("mid_after_acc",   32'(acc),       32'h0);
        chk("mid_after_cnt",   32'(op_cnt),    32'h0);

        // Counter wrap: 256 back-to-back loads with res_ready held high
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_load = 1'b1;
        for (int i = 0; i < 255; i++) begin
            cmd_data = 4'(i);
            tick();
            tick();
        end
        chk("cnt_ff", 32'(op_cnt), 32'hFF);
        cmd_data = 4'h9;
        tick();
        chk("cnt_last_data", 32'(res_data), 32'h9);
        tick();
        cmd_valid = 1'b0;
        chk("cnt_wrap",       32'(op_cnt),    32'h0);
        chk("cnt_wrap_ready", 32'(cmd_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven front end for the 4-bit ALU datapath. It accepts operation commands over a valid/ready interface and drives the registered A, B and SEL inputs of `ALU_4bit`. It captures the ALU's combinational OUT into an accumulator and returns each result over a valid/ready response interface. The block sits directly upstream of `ALU_4bit`, owns its operands, and closes the loop on its output.

## Interface
- `WIDTH`, default 4: operand, accumulator and result width; matches the ALU data width.
- `SEL_W`, default 3: ALU operation select width.
- `CNT_W`, default 8: width of the completed-operation counter.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `CMD_VALID` in 1: command present.
- `CMD_READY` out 1: block can accept a command.
- `CMD_LOAD` in 1: 1 = load `CMD_DATA` into ACC and bypass the ALU; 0 = execute an ALU operation.
- `CMD_OP` in SEL_W: ALU select for execute commands.
- `CMD_DATA` in WIDTH: B operand for execute commands, or the load value.
- `ALU_A` out WIDTH: registered A operand to the ALU.
- `ALU_B` out WIDTH: registered B operand to the ALU.
- `ALU_SEL` out SEL_W: registered select to the ALU.
- `ALU_OUT` in WIDTH: combinational result from the ALU.
- `RES_VALID` out 1: result available.
- `RES_READY` in 1: consumer accepts the result.
- `RES_DATA` out WIDTH: result value, equal to the new ACC.
- `RES_ZERO` out 1: result-is-zero flag (see Configuration).
- `ACC` out WIDTH: current accumulator value.
- `OP_CNT` out CNT_W: number of completed result handshakes.

## Operation
- FSM states: IDLE, EXEC, RESP.
- `CMD_READY` = (state == IDLE). It is decoded from state only and has no combinational path from `CMD_VALID`.

IDLE:
- On `CMD_VALID && CMD_READY` with `CMD_LOAD` = 0:
  - `ALU_A <= ACC`, `ALU_B <= CMD_DATA`, `ALU_SEL <= CMD_OP`.
  - Next state is EXEC.
- On `CMD_VALID && CMD_READY` with `CMD_LOAD` = 1:
  - `ACC <= CMD_DATA`, `RES_DATA <= CMD_DATA`, `RES_VALID <= 1`.
  - Next state is RESP. ALU_* registers are unchanged.

EXEC (exactly one cycle):
- `ACC <= ALU_OUT`, `RES_DATA <= ALU_OUT`, `RES_VALID <= 1`.
- Next state is RESP.

RESP:
- `RES_VALID`, `RES_DATA` and `RES_ZERO` are held stable until `RES_READY` = 1.
- On the handshake: `RES_VALID <= 0`, `OP_CNT <= OP_CNT + 1`, next state is IDLE.

Arithmetic and boundary conditions:
- `OP_CNT` is modulo 2^CNT_W; 0xFF + 1 wraps to 0x00 with no saturation or flag.
- The block does not interpret `ALU_SEL`. Results are whatever the ALU returns, truncated to WIDTH.
- A `CMD_VALID` held while busy is not accepted; command fields may change freely until acceptance.
- If `RES_READY` is asserted before `RES_VALID`, it is ignored.
- `RST` asserted in any state forces the reset values immediately. Any in-flight command is dropped and no result is produced.

Reset values (all outputs):
- State IDLE.
- `ACC`, `ALU_A`, `ALU_B`, `ALU_SEL`, `RES_DATA`, `OP_CNT` = 0.
- `RES_VALID` = 0, `RES_ZERO` = 0.
- `CMD_READY` = 1.

## Timing
- Execute command accepted at edge k:
  - ALU inputs are valid after edge k.
  - ACC and `RES_DATA` update and `RES_VALID` rises at edge k+1.
- Load command accepted at edge k: `RES_VALID` rises at edge k.
- Earliest next command acceptance:
  - Execute: edge k+3 (k+1 capture, k+2 result handshake if `RES_READY` is held high, k+3 IDLE).
  - Load: edge k+2.
- `ALU_OUT` is sampled only in EXEC. The ALU path must settle within one clock.
- Back-pressure: `RES_READY` held low holds RESP indefinitely with all outputs stable.

## Configuration
- Macro: `ALU_SEQ_ZERO_FLAG_EN`.
- When defined: `RES_ZERO` is registered alongside `RES_DATA` and equals (`RES_DATA` == 0) while `RES_VALID` = 1. It returns to 0 when the result handshake completes.
- When undefined: the `RES_ZERO` port still exists but is tied to 0, and no flag logic is synthesized.

## Test plan
The bench ALU stub returns (`ALU_A` + `ALU_B`) mod 16.
- Reset: assert `RST` mid-cycle. All outputs reach their reset values asynchronously, and `CMD_READY` = 1 after release.
- Load then add:
  - LOAD 0x5 → `RES_DATA` = 0x5.
  - Execute with `CMD_DATA` = 0x3, `CMD_OP` = 3'b000 → `ALU_A` = 0x5, `ALU_B` = 0x3, `ALU_SEL` = 000; `RES_DATA` = `ACC` = 0x8 one cycle later; `OP_CNT` = 2.
- Back-pressure: hold `RES_READY` = 0 for 5 cycles after a result.
  - `RES_VALID`/`RES_DATA` stay stable and `CMD_READY` stays 0.
  - A new command held on `CMD_VALID` is not accepted until after the handshake.
- Wrap and zero flag: LOAD 0xF, then execute with `CMD_DATA` = 0x1 → `RES_DATA` = 0x0. `RES_ZERO` = 1 with the macro defined, 0 without.
- Reset mid-operation: assert `RST` while in EXEC. No result appears, `ACC` = 0, `OP_CNT` unchanged from 0.
- Counter wrap: complete 256 commands with `CNT_W` = 8 → `OP_CNT` returns to 0x00.
